// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry in-order retirement queue with 4-wide allocate/retire
//
// Purpose: tracks issued instructions by 4-bit owner tag, captures results from
// two completion ports and retires up to four consecutive completed entries per
// cycle, oldest first, through a registered retirement write port.
//
// Optional feature macro: ROB_FLUSH_EN (adds the flush input).
//
// Ports (lane i of a flat bus sits in the MSB-most slice, lane 0 = MSBs):
//   clk, rst_n                          clock, async active-low reset
//   flush                               (ROB_FLUSH_EN only) discard all entries
//   alloc_valid_flat[4]/alloc_dest_flat[16]   allocate request lanes
//   alloc_ready                         count <= 12
//   alloc_tag_flat[16]                  tag per allocate lane (tail+k)
//   cmpl_valid[2]/cmpl_tag_flat[8]/cmpl_data_flat[32]   completion ports 0,1
//   retirement_write_data_enable_flat[4], retirement_target_reg_flat[16],
//   retirement_write_data_flat[64], instruction_writer_flat[16]   retire lanes
//   count[5]                            occupied entries 0..16

module reorder_buffer #(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef ROB_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [3:0]  alloc_valid_flat,
    input  logic [15:0] alloc_dest_flat,
    output logic        alloc_ready,
    output logic [15:0] alloc_tag_flat,
    input  logic [1:0]  cmpl_valid,
    input  logic [7:0]  cmpl_tag_flat,
    input  logic [31:0] cmpl_data_flat,
    output logic [3:0]  retirement_write_data_enable_flat,
    output logic [15:0] retirement_target_reg_flat,
    output logic [63:0] retirement_write_data_flat,
    output logic [15:0] instruction_writer_flat,
    output logic [4:0]  count
);

    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [DEPTH-1:0]        done_q, done_d;
    logic [DEPTH-1:0][3:0]   dest_q, dest_d;
    logic [DEPTH-1:0][15:0]  data_q, data_d;
    logic [3:0]              head_q, head_d;
    logic [3:0]              tail_q, tail_d;
    logic [4:0]              count_q, count_d;

    logic [3:0]              ret_en_q, ret_en_d;
    logic [15:0]             ret_tgt_q, ret_tgt_d;
    logic [63:0]             ret_data_q, ret_data_d;
    logic [15:0]             ret_wr_q, ret_wr_d;

    logic [3:0]              c0_tag, c1_tag;
    logic [15:0]             c0_data, c1_data;
    logic                    c0_v, c1_v;
    logic                    alloc_fire;
    logic [2:0]              n_alloc, n_ret;
    logic                    stop;
    logic [3:0]              idx;

    assign c0_v    = cmpl_valid[1];
    assign c1_v    = cmpl_valid[0];
    assign c0_tag  = cmpl_tag_flat[7:4];
    assign c1_tag  = cmpl_tag_flat[3:0];
    assign c0_data = cmpl_data_flat[31:16];
    assign c1_data = cmpl_data_flat[15:0];

    // Readiness uses the pre-retire count so four free slots are guaranteed;
    // this also keeps new allocations clear of entries retiring this cycle.
    assign alloc_ready = (count_q <= 5'(DEPTH - RETIRE_W));
    assign alloc_fire  = alloc_ready && (|alloc_valid_flat);

    always_comb begin
        alloc_tag_flat = '0;
        for (int k = 0; k < RETIRE_W; k++) begin
            alloc_tag_flat[4*(3-k) +: 4] = tail_q + 4'(k);
        end
    end

    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        dest_d     = dest_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ret_en_d   = '0;
        ret_tgt_d  = '0;
        ret_data_d = '0;
        ret_wr_d   = '0;
        n_alloc    = '0;
        n_ret      = '0;
        stop       = 1'b0;
        idx        = '0;

        // Completion: port 1 is applied last so it wins on a shared tag.
        if (c0_v && valid_q[c0_tag]) begin
            done_d[c0_tag] = 1'b1;
            data_d[c0_tag] = c0_data;
        end
        if (c1_v && valid_q[c1_tag]) begin
            done_d[c1_tag] = 1'b1;
            data_d[c1_tag] = c1_data;
        end

        // Retire the longest done prefix from head; uses pre-edge done state,
        // so a completion needs one more edge before it can retire.
        for (int j = 0; j < RETIRE_W; j++) begin
            idx = head_q + 4'(j);
            if (!stop && (5'(j) < count_q) && valid_q[idx] && done_q[idx]) begin
                n_ret                        = n_ret + 3'd1;
                valid_d[idx]                 = 1'b0;
                done_d[idx]                  = 1'b0;
                ret_en_d[3-j]                = 1'b1;
                ret_tgt_d[4*(3-j) +: 4]      = dest_q[idx];
                ret_data_d[16*(3-j) +: 16]   = data_q[idx];
                ret_wr_d[4*(3-j) +: 4]       = idx;
            end else begin
                stop = 1'b1;
            end
        end

        // Allocation targets only free slots, so it never collides with the
        // completion or retire updates above.
        for (int k = 0; k < RETIRE_W; k++) begin
            idx = tail_q + 4'(k);
            if (alloc_fire && alloc_valid_flat[3-k]) begin
                n_alloc      = n_alloc + 3'd1;
                valid_d[idx] = 1'b1;
                done_d[idx]  = 1'b0;
                dest_d[idx]  = alloc_dest_flat[4*(3-k) +: 4];
            end
        end

        head_d  = head_q + {1'b0, n_ret};
        tail_d  = tail_q + {1'b0, n_alloc};
        count_d = count_q + {2'b00, n_alloc} - {2'b00, n_ret};

`ifdef ROB_FLUSH_EN
        if (flush) begin
            valid_d    = '0;
            done_d     = '0;
            head_d     = head_q;
            tail_d     = head_q;
            count_d    = '0;
            ret_en_d   = '0;
            ret_tgt_d  = '0;
            ret_data_d = '0;
            ret_wr_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            done_q     <= '0;
            dest_q     <= '0;
            data_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ret_en_q   <= '0;
            ret_tgt_q  <= '0;
            ret_data_q <= '0;
            ret_wr_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            dest_q     <= dest_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ret_en_q   <= ret_en_d;
            ret_tgt_q  <= ret_tgt_d;
            ret_data_q <= ret_data_d;
            ret_wr_q   <= ret_wr_d;
        end
    end

    assign retirement_write_data_enable_flat = ret_en_q;
    assign retirement_target_reg_flat        = ret_tgt_q;
    assign retirement_write_data_flat        = ret_data_q;
    assign instruction_writer_flat           = ret_wr_q;
    assign count                             = count_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer

module tb_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  alloc_valid_flat;
    logic [15:0] alloc_dest_flat;
    logic        alloc_ready;
    logic [15:0] alloc_tag_flat;
    logic [1:0]  cmpl_valid;
    logic [7:0]  cmpl_tag_flat;
    logic [31:0] cmpl_data_flat;
    logic [3:0]  ret_en;
    logic [15:0] ret_tgt;
    logic [63:0] ret_data;
    logic [15:0] ret_wr;
    logic [4:0]  count;

    reorder_buffer dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
`ifdef ROB_FLUSH_EN
        .flush                             (flush),
`endif
        .alloc_valid_flat                  (alloc_valid_flat),
        .alloc_dest_flat                   (alloc_dest_flat),
        .alloc_ready                       (alloc_ready),
        .alloc_tag_flat                    (alloc_tag_flat),
        .cmpl_valid                        (cmpl_valid),
        .cmpl_tag_flat                     (cmpl_tag_flat),
        .cmpl_data_flat                    (cmpl_data_flat),
        .retirement_write_data_enable_flat (ret_en),
        .retirement_target_reg_flat        (ret_tgt),
        .retirement_write_data_flat        (ret_data),
        .instruction_writer_flat           (ret_wr),
        .count                             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [15:0] tgt;
        logic [63:0] dat;
        logic [15:0] wr;
    } ret_t;

    typedef struct {
        logic [3:0]  av;
        logic [15:0] ad;
        logic [1:0]  cv;
        logic [7:0]  ct;
        logic [31:0] cd;
        logic        push;
        ret_t        ret;
        logic [4:0]  exp_count;
        logic        exp_ready;
        logic [15:0] exp_tag;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    ret_t sb[$];
    ret_t mon_r;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Any retire pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ret_en != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire en=%b writer=%h target=%h", ret_en, ret_wr, ret_tgt);
            end else begin
                mon_r = sb.pop_front();
                if (ret_en !== mon_r.en || ret_tgt !== mon_r.tgt ||
                    ret_data !== mon_r.dat || ret_wr !== mon_r.wr) begin
                    errors++;
                    $display("FAIL retire actual en=%b tgt=%h data=%h wr=%h expected en=%b tgt=%h data=%h wr=%h",
                             ret_en, ret_tgt, ret_data, ret_wr, mon_r.en, mon_r.tgt, mon_r.dat, mon_r.wr);
                end
            end
        end
    end

    // Called at a negedge; drives for one posedge and returns at the next negedge.
    task automatic step(input logic [3:0] av, input logic [15:0] ad, input logic [1:0] cv,
                        input logic [7:0] ct, input logic [31:0] cd, input logic fl);
        alloc_valid_flat = av;
        alloc_dest_flat  = ad;
        cmpl_valid       = cv;
        cmpl_tag_flat    = ct;
        cmpl_data_flat   = cd;
        flush            = fl;
        @(posedge clk);
        #1;
        alloc_valid_flat = '0;
        alloc_dest_flat  = '0;
        cmpl_valid       = '0;
        cmpl_tag_flat    = '0;
        cmpl_data_flat   = '0;
        flush            = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle();
        step(4'h0, 16'h0, 2'b00, 8'h00, 32'h0, 1'b0);
    endtask

    task automatic expect_ret(input logic [3:0] en, input logic [15:0] tgt,
                              input logic [63:0] dat, input logic [15:0] wr);
        ret_t r;
        r.en = en; r.tgt = tgt; r.dat = dat; r.wr = wr;
        sb.push_back(r);
    endtask

    task automatic chk_state(input string tag, input logic [4:0] c, input logic rdy, input logic [15:0] t);
        chk({tag, "_count"}, 64'(count), 64'(c));
        chk({tag, "_ready"}, 64'(alloc_ready), 64'(rdy));
        chk({tag, "_tag"}, 64'(alloc_tag_flat), 64'(t));
    endtask

    localparam ret_t NR = '{4'h0, 16'h0, 64'h0, 16'h0};

    initial begin
        logic [3:0]  t;
        logic [15:0] ad;
        vec_t v;

        rst_n = 1'b0;
        flush = 1'b0;
        alloc_valid_flat = '0; alloc_dest_flat = '0;
        cmpl_valid = '0; cmpl_tag_flat = '0; cmpl_data_flat = '0;
        repeat (2) @(negedge clk);
        chk_state("reset", 5'd0, 1'b1, 16'h0123);
        chk("reset_en", 64'(ret_en), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_state("release", 5'd0, 1'b1, 16'h0123);

        //          av    ad        cv     ct     cd                  push ret                                                          cnt  rdy tag
        tbl.push_back('{4'hF, 16'h5271, 2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd4, 1, 16'h4567});
        tbl.push_back('{4'h0, 16'h0,    2'b11, 8'h12, {16'd0, 16'd9},     0, NR,                                                           5'd4, 1, 16'h4567});
        tbl.push_back('{4'h0, 16'h0,    2'b11, 8'h30, {16'd3, 16'd70},    1, '{4'hF, 16'h5271, 64'h0046_0000_0009_0003, 16'h0123},       5'd4, 1, 16'h4567});
        tbl.push_back('{4'h0, 16'h0,    2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd0, 1, 16'h4567});
        tbl.push_back('{4'hE, 16'h3460, 2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd3, 1, 16'h789A});
        tbl.push_back('{4'h0, 16'h0,    2'b10, 8'h50, {16'h1111, 16'h0},  0, NR,                                                           5'd3, 1, 16'h789A});
        tbl.push_back('{4'h0, 16'h0,    2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd3, 1, 16'h789A});
        tbl.push_back('{4'h0, 16'h0,    2'b10, 8'h40, {16'h2222, 16'h0},  1, '{4'hC, 16'h3400, 64'h2222_1111_0000_0000, 16'h4500},       5'd3, 1, 16'h789A});
        tbl.push_back('{4'h0, 16'h0,    2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd1, 1, 16'h789A});
        tbl.push_back('{4'h0, 16'h0,    2'b01, 8'h06, {16'h0, 16'h3333},  1, '{4'h8, 16'h6000, 64'h3333_0000_0000_0000, 16'h6000},       5'd1, 1, 16'h789A});
        tbl.push_back('{4'h8, 16'h9000, 2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd1, 1, 16'h89AB});
        tbl.push_back('{4'h0, 16'h0,    2'b11, 8'h77, {16'hAAAA, 16'hBBBB}, 1, '{4'h8, 16'h9000, 64'hBBBB_0000_0000_0000, 16'h7000},     5'd1, 1, 16'h89AB});
        tbl.push_back('{4'h0, 16'h0,    2'b10, 8'h90, {16'h1234, 16'h0},  0, NR,                                                           5'd0, 1, 16'h89AB});
        tbl.push_back('{4'h8, 16'h2000, 2'b10, 8'h80, {16'h5555, 16'h0},  0, NR,                                                           5'd1, 1, 16'h9ABC});
        tbl.push_back('{4'h0, 16'h0,    2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd1, 1, 16'h9ABC});
        tbl.push_back('{4'h0, 16'h0,    2'b10, 8'h80, {16'h0808, 16'h0},  1, '{4'h8, 16'h2000, 64'h0808_0000_0000_0000, 16'h8000},       5'd1, 1, 16'h9ABC});
        tbl.push_back('{4'h0, 16'h0,    2'b00, 8'h00, 32'h0,              0, NR,                                                           5'd0, 1, 16'h9ABC});

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.push) expect_ret(v.ret.en, v.ret.tgt, v.ret.dat, v.ret.wr);
            step(v.av, v.ad, v.cv, v.ct, v.cd, 1'b0);
            chk_state($sformatf("row%0d", i), v.exp_count, v.exp_ready, v.exp_tag);
        end

        // Fill to 16 entries starting at tag 9; dest of each entry equals its tag.
        for (int g = 0; g < 4; g++) begin
            t  = 4'(9 + 4 * g);
            ad = {t, t + 4'd1, t + 4'd2, t + 4'd3};
            step(4'hF, ad, 2'b00, 8'h00, 32'h0, 1'b0);
            chk_state($sformatf("fill%0d", g), 5'(4 * (g + 1)), (g < 3), {t + 4'd4, t + 4'd5, t + 4'd6, t + 4'd7});
        end
        step(4'hF, 16'h1111, 2'b00, 8'h00, 32'h0, 1'b0);
        chk_state("full_drop", 5'd16, 1'b0, 16'h9ABC);
        step(4'h0, 16'h0, 2'b11, 8'hAB, {16'h100A, 16'h100B}, 1'b0);
        chk_state("full_cmpl1", 5'd16, 1'b0, 16'h9ABC);
        expect_ret(4'hF, 16'h9ABC, 64'h1009_100A_100B_100C, 16'h9ABC);
        step(4'h0, 16'h0, 2'b11, 8'hC9, {16'h100C, 16'h1009}, 1'b0);
        chk_state("full_cmpl2", 5'd16, 1'b0, 16'h9ABC);
        idle();
        chk_state("full_retire", 5'd12, 1'b1, 16'h9ABC);

        // Walk head to 14 then retire across the 15 -> 0 wrap.
        expect_ret(4'h8, 16'hD000, 64'h100D_0000_0000_0000, 16'hD000);
        step(4'h0, 16'h0, 2'b10, 8'hD0, {16'h100D, 16'h0}, 1'b0);
        chk_state("wrap_a", 5'd12, 1'b1, 16'h9ABC);
        idle();
        chk_state("wrap_b", 5'd11, 1'b1, 16'h9ABC);
        step(4'h0, 16'h0, 2'b11, 8'hF0, {16'h100F, 16'h1000}, 1'b0);
        chk_state("wrap_c", 5'd11, 1'b1, 16'h9ABC);
        expect_ret(4'hF, 16'hEF01, 64'h100E_100F_1000_1001, 16'hEF01);
        step(4'h0, 16'h0, 2'b11, 8'h1E, {16'h1001, 16'h100E}, 1'b0);
        chk_state("wrap_d", 5'd11, 1'b1, 16'h9ABC);
        idle();
        chk_state("wrap_e", 5'd7, 1'b1, 16'h9ABC);

`ifdef ROB_FLUSH_EN
        expect_ret(4'h8, 16'h2000, 64'h1002_0000_0000_0000, 16'h2000);
        step(4'h0, 16'h0, 2'b10, 8'h20, {16'h1002, 16'h0}, 1'b0);
        idle();
        chk_state("pre_flush", 5'd6, 1'b1, 16'h9ABC);
        step(4'h0, 16'h0, 2'b10, 8'h30, {16'h1003, 16'h0}, 1'b0);
        chk_state("flush_a", 5'd6, 1'b1, 16'h9ABC);
        step(4'h0, 16'h0, 2'b10, 8'h40, {16'h1004, 16'h0}, 1'b1);
        chk_state("flush_b", 5'd0, 1'b1, 16'h3456);
        idle();
        chk_state("flush_c", 5'd0, 1'b1, 16'h3456);
`endif

        // Reset mid-operation takes effect without a clock edge.
        step(4'hF, 16'h1234, 2'b00, 8'h00, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 5'd0, 1'b1, 16'h0123);
        chk("async_rst_en", 64'(ret_en), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
